// File: rtl/butterfly_stream.sv
// butterfly_stream: 3-stage pipelined radix-2 complex butterfly, Y=(A+W*B)/2, Z=(A-W*B)/2, valid/ready stream.
// Define BUTTERFLY_SATURATE_EN to clamp results and drive a sticky sat_flag; otherwise results wrap and sat_flag is 0.
module butterfly_stream #(
    parameter int DATA_W  = 8,
    parameter int TW_FRAC = DATA_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re, a_im, b_re, b_im, w_re, w_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_re, y_im, z_re, z_im,
    output logic              sat_flag
);
    localparam int PW = 2 * DATA_W;
    localparam int WW = 2 * DATA_W + 1;
    logic en, ld3;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, sat_q, sat_d;
    logic signed [DATA_W-1:0] a1_re_q, a1_im_q, b1_re_q, b1_im_q, w1_re_q, w1_im_q;
    logic signed [DATA_W-1:0] a1_re_d, a1_im_d, b1_re_d, b1_im_d, w1_re_d, w1_im_d;
    logic signed [DATA_W-1:0] a2_re_q, a2_im_q, a2_re_d, a2_im_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q, p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [WW-1:0] wb_re, wb_im, ax_re, ax_im, ys_re, ys_im, zs_re, zs_im;
    logic [DATA_W-1:0] y_re_q, y_im_q, z_re_q, z_im_q, y_re_d, y_im_d, z_re_d, z_im_d;

`ifdef BUTTERFLY_SATURATE_EN
    function automatic logic ovf(input logic signed [WW-1:0] x);
        logic signed [DATA_W-1:0] t;
        t = DATA_W'(x);
        return x != WW'(t);
    endfunction
    function automatic logic [DATA_W-1:0] fit(input logic signed [WW-1:0] x);
        return !ovf(x) ? DATA_W'(x) : x[WW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
`else
    function automatic logic [DATA_W-1:0] fit(input logic signed [WW-1:0] x);
        return DATA_W'(x);
    endfunction
`endif

    always_comb begin
        en = !v3_q || out_ready;
        ld3 = en && v2_q;
        v1_d = en ? in_valid : v1_q;
        v2_d = en ? v1_q : v2_q;
        v3_d = en ? v2_q : v3_q;
        a1_re_d = en ? a_re : a1_re_q;
        a1_im_d = en ? a_im : a1_im_q;
        b1_re_d = en ? b_re : b1_re_q;
        b1_im_d = en ? b_im : b1_im_q;
        w1_re_d = en ? w_re : w1_re_q;
        w1_im_d = en ? w_im : w1_im_q;
        a2_re_d = en ? a1_re_q : a2_re_q;
        a2_im_d = en ? a1_im_q : a2_im_q;
        p_rr_d = en ? PW'(w1_re_q) * PW'(b1_re_q) : p_rr_q;
        p_ii_d = en ? PW'(w1_im_q) * PW'(b1_im_q) : p_ii_q;
        p_ri_d = en ? PW'(w1_re_q) * PW'(b1_im_q) : p_ri_q;
        p_ir_d = en ? PW'(w1_im_q) * PW'(b1_re_q) : p_ir_q;
        wb_re = (WW'(p_rr_q) - WW'(p_ii_q)) >>> TW_FRAC;
        wb_im = (WW'(p_ri_q) + WW'(p_ir_q)) >>> TW_FRAC;
        ax_re = WW'(a2_re_q);
        ax_im = WW'(a2_im_q);
        ys_re = (ax_re + wb_re) >>> 1;
        ys_im = (ax_im + wb_im) >>> 1;
        zs_re = (ax_re - wb_re) >>> 1;
        zs_im = (ax_im - wb_im) >>> 1;
        // outputs only reload when a valid beat enters stage 3
        y_re_d = ld3 ? fit(ys_re) : y_re_q;
        y_im_d = ld3 ? fit(ys_im) : y_im_q;
        z_re_d = ld3 ? fit(zs_re) : z_re_q;
        z_im_d = ld3 ? fit(zs_im) : z_im_q;
`ifdef BUTTERFLY_SATURATE_EN
        sat_d = sat_q || (ld3 && (ovf(ys_re) || ovf(ys_im) || ovf(zs_re) || ovf(zs_im)));
`else
        sat_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {v1_q, v2_q, v3_q, sat_q} <= '0;
            {a1_re_q, a1_im_q, b1_re_q, b1_im_q, w1_re_q, w1_im_q} <= '0;
            {a2_re_q, a2_im_q, p_rr_q, p_ii_q, p_ri_q, p_ir_q} <= '0;
            {y_re_q, y_im_q, z_re_q, z_im_q} <= '0;
        end else begin
            {v1_q, v2_q, v3_q, sat_q} <= {v1_d, v2_d, v3_d, sat_d};
            {a1_re_q, a1_im_q, b1_re_q, b1_im_q, w1_re_q, w1_im_q} <= {a1_re_d, a1_im_d, b1_re_d, b1_im_d, w1_re_d, w1_im_d};
            {a2_re_q, a2_im_q, p_rr_q, p_ii_q, p_ri_q, p_ir_q} <= {a2_re_d, a2_im_d, p_rr_d, p_ii_d, p_ri_d, p_ir_d};
            {y_re_q, y_im_q, z_re_q, z_im_q} <= {y_re_d, y_im_d, z_re_d, z_im_d};
        end
    end

    assign in_ready = en;
    assign out_valid = v3_q;
    assign {y_re, y_im, z_re, z_im} = {y_re_q, y_im_q, z_re_q, z_im_q};
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_butterfly_stream.sv
// tb_butterfly_stream: directed and random stimulus for butterfly_stream, scored against an integer-arithmetic model.
module tb_butterfly_stream;
    localparam int DW = 8;
    localparam int TW = 7;
`ifdef BUTTERFLY_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {
        logic [7:0] yr, yi, zr, zi;
        bit c;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, sat_flag;
    logic [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im, y_re, y_im, z_re, z_im;
    exp_t q[$];
    int n_tests = 0, n_fail = 0, cnum = 0, last_stall = -1;
    bit msat = 1'b0, hold = 1'b0, acc_last = 1'b0;
    logic [31:0] snap;

    butterfly_stream #(.DATA_W(DW), .TW_FRAC(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_re(y_re), .y_im(y_im), .z_re(z_re), .z_im(z_im), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // floor(x / d) for positive d
    function automatic int fdiv(input int x, input int d);
        return (x - (((x % d) + d) % d)) / d;
    endfunction

    function automatic logic [7:0] nar(input int x, inout bit c);
`ifdef BUTTERFLY_SATURATE_EN
        if (x > 127 || x < -128) begin
            c = 1'b1;
            return x > 0 ? 8'h7f : 8'h80;
        end
`endif
        return 8'(x);
    endfunction

    function automatic exp_t model(input int ar, ai, br, bi, wr, wi);
        exp_t e;
        bit c = 1'b0;
        int wbr, wbi;
        wbr = fdiv(wr * br - wi * bi, 1 << TW);
        wbi = fdiv(wr * bi + wi * br, 1 << TW);
        e.yr = nar(fdiv(ar + wbr, 2), c);
        e.yi = nar(fdiv(ai + wbi, 2), c);
        e.zr = nar(fdiv(ar - wbr, 2), c);
        e.zi = nar(fdiv(ai - wbi, 2), c);
        e.c = c;
        e.acc = cnum;
        return e;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // one clock cycle: drive at the falling edge, check just after, then advance to the next falling edge
    task automatic cyc(input bit v, input int ar, ai, br, bi, wr, wi, input bit rdy);
        exp_t e;
        cnum++;
        in_valid = v;
        a_re = 8'(ar); a_im = 8'(ai); b_re = 8'(br); b_im = 8'(bi); w_re = 8'(wr); w_im = 8'(wi);
        out_ready = rdy;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (hold) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", {y_re, y_im, z_re, z_im}, snap);
        end
        hold = out_valid && !out_ready;
        snap = {y_re, y_im, z_re, z_im};
        if (hold) last_stall = cnum;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_beat", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("y_re", $signed(y_re), $signed(e.yr));
                chk("y_im", $signed(y_im), $signed(e.yi));
                chk("z_re", $signed(z_re), $signed(e.zr));
                chk("z_im", $signed(z_im), $signed(e.zi));
                msat |= e.c;
                chk("sat_flag", sat_flag, msat);
                if (e.acc > last_stall) chk("latency", cnum - e.acc, 3);
            end
        end
        acc_last = v && in_ready;
        if (acc_last) q.push_back(model(ar, ai, br, bi, wr, wi));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    endtask

    task automatic dir(input string tag, input int ar, ai, br, bi, wr, wi, ey_re, ey_im, ez_re, ez_im);
        cyc(1'b1, ar, ai, br, bi, wr, wi, 1'b1);
        idle(2);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_y_re"}, $signed(y_re), ey_re);
        chk({tag, "_y_im"}, $signed(y_im), ey_im);
        chk({tag, "_z_re"}, $signed(z_re), ez_re);
        chk({tag, "_z_im"}, $signed(z_im), ez_im);
        idle(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {y_re, y_im, z_re, z_im}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat", sat_flag, 0);
        q.delete();
        msat = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        bit [7:0] pat = 8'b1110_1001;
        int sent = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        {a_re, a_im, b_re, b_im, w_re, w_im} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        dir("real", 16, 0, 32, 0, 64, 0, 16, 0, 0, 0);
        dir("neg_j", 0, 0, 32, 0, 0, -128, 0, -16, 0, 16);
        dir("floor_pos", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dir("floor_neg", -1, 0, 0, 0, 0, 0, -1, 0, -1, 0);
        dir("ovf", 0, 127, -128, -128, -128, -128, 0, SAT ? 127 : -65, 0, -65);
        chk("ovf_sat", sat_flag, SAT);
        for (int k = 0; k < 10; k++) cyc(1'b1, k, -k, 0, 0, 0, 0, 1'b1);
        idle(3);
        chk("sat_sticky", sat_flag, SAT);
        for (int k = 0; k < 100 && (sent < 8 || q.size() > 0); k++) begin
            cyc(sent < 8, 4 * sent, 0, 32, -16, 64, 32, pat[k % 8]);
            if (acc_last) sent++;
        end
        chk("bp_sent", sent, 8);
        chk("bp_drained", q.size(), 0);
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, rnd(), rnd(), rnd(), rnd(),
                $urandom_range(0, 7) == 0 ? -128 : rnd(), rnd(), $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
        chk("rand_drained", q.size(), 0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 10 + k, 0, 0, 0, 0, 0, 1'b1);
        do_reset();
        idle(4);
        dir("post_rst", 5, 3, 64, -32, 64, 0, 18, -7, -14, 9);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
